we_regfile: RTL and testbench

WE_REGFILE -- requirements
Module: we_regfile

---
 rtl/we_regfile_pkg.sv | 18 +
 rtl/we_regfile_byte_we_reg.sv | 42 ++++
 rtl/we_regfile.sv | 146 ++++++++++++++
 tb/tb_we_regfile.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/we_regfile_pkg.sv
// -----------------------------------------------------------------------------
// we_regfile_pkg
// Shared definitions for the byte-write-enable register file.
//   fsm_state_t   : clear-sequencer state (IDLE, CLEAR)
//   DEFAULT_WIDTH : default entry width in bits (multiple of 8)
//   DEFAULT_DEPTH : default number of entries
// -----------------------------------------------------------------------------
package we_regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fsm_state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/we_regfile_byte_we_reg.sv
// -----------------------------------------------------------------------------
// byte_we_reg
// One register-file entry with per-byte write enables and a dirty flag.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear of data and dirty flag
//   we       : accepted write to this entry
//   strb     : per-byte enable, bit b covers data[8b+7:8b]
//   data     : write data
//   q        : stored entry value
//   dirty    : set by any accepted write, even one with no strobes
// -----------------------------------------------------------------------------
module byte_we_reg #(
    parameter int WIDTH = 32,
    parameter int STRB  = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [STRB-1:0]  strb,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             dirty
);

    // Reset and the sequential clear both win over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q     <= '0;
            dirty <= 1'b0;
        end else if (we) begin
            for (int b = 0; b < STRB; b++) begin
                if (strb[b]) begin
                    q[8*b +: 8] <= data[8*b +: 8];
                end
            end
            dirty <= 1'b1;
        end
    end

endmodule

// File: rtl/we_regfile.sv
// -----------------------------------------------------------------------------
// we_regfile
// Register file with byte-strobed writes, registered 1-cycle reads, per-entry
// dirty bits and a sequential clear engine (one entry per cycle).
// Build option: define WE_REGFILE_BYPASS_EN to forward a same-cycle write to a
// read of the same address; otherwise such a read returns the pre-write data.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   wr_valid_in   : write request       wr_ready_out : low while clearing
//   wr_addr_in    : write index         wr_data_in   : write data
//   wr_strb_in    : per-byte write enable
//   rd_en_in      : read request        rd_addr_in   : read index
//   rd_data_out   : registered read data, held when no read
//   rd_valid_out  : one-cycle pulse after each read request
//   clr_in        : start clearing all entries
//   busy_out      : clear in progress
//   dirty_out     : per-entry written-since-reset/clear flags
// Indices >= DEPTH are accepted on write without effect and read as zero.
// -----------------------------------------------------------------------------
module we_regfile
    import we_regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int STRB  = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid_in,
    output logic             wr_ready_out,
    input  logic [AW-1:0]    wr_addr_in,
    input  logic [WIDTH-1:0] wr_data_in,
    input  logic [STRB-1:0]  wr_strb_in,
    input  logic             rd_en_in,
    input  logic [AW-1:0]    rd_addr_in,
    output logic [WIDTH-1:0] rd_data_out,
    output logic             rd_valid_out,
    input  logic             clr_in,
    output logic             busy_out,
    output logic [DEPTH-1:0] dirty_out
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    fsm_state_t       state;
    logic [AW-1:0]    clr_idx;
    logic             wr_fire;
    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [DEPTH-1:0] entry_we;
    logic [DEPTH-1:0] entry_clr;
    logic [WIDTH-1:0] rd_word;
    logic             rd_hit;

    assign wr_ready_out = ~busy_out;
    assign wr_fire      = wr_valid_in & wr_ready_out;

    // Per-entry decode: an out-of-range address matches no entry, so such a
    // write is accepted but changes nothing.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign entry_we[i]  = wr_fire && (wr_addr_in == AW'(i));
        assign entry_clr[i] = (state == CLEAR) && (clr_idx == AW'(i));

        byte_we_reg #(
            .WIDTH (WIDTH),
            .STRB  (STRB)
        ) u_entry (
            .clk   (clk),
            .rst   (rst),
            .clr   (entry_clr[i]),
            .we    (entry_we[i]),
            .strb  (wr_strb_in),
            .data  (wr_data_in),
            .q     (entry_q[i]),
            .dirty (dirty_out[i])
        );
    end

    // Read mux; rd_hit guards the bypass so out-of-range reads stay zero.
    always_comb begin
        rd_word = '0;
        rd_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_in == AW'(i)) begin
                rd_word = entry_q[i];
                rd_hit  = 1'b1;
            end
        end
`ifdef WE_REGFILE_BYPASS_EN
        if (rd_hit && wr_fire && (wr_addr_in == rd_addr_in)) begin
            for (int b = 0; b < STRB; b++) begin
                if (wr_strb_in[b]) begin
                    rd_word[8*b +: 8] = wr_data_in[8*b +: 8];
                end
            end
        end
`endif
    end

    // Registered read port: data holds between reads, valid pulses once.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_out  <= '0;
            rd_valid_out <= 1'b0;
        end else begin
            rd_valid_out <= rd_en_in;
            if (rd_en_in) begin
                rd_data_out <= rd_word;
            end
        end
    end

    // Clear sequencer. busy_out is registered alongside the state so it is
    // high for exactly the DEPTH cycles spent in CLEAR; clr_in is only
    // sampled in IDLE, so requests during a clear are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            clr_idx  <= '0;
            busy_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_in) begin
                        state    <= CLEAR;
                        clr_idx  <= '0;
                        busy_out <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_idx == LAST_IDX) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_we_regfile.sv
// -----------------------------------------------------------------------------
// tb_we_regfile
// Directed bench for we_regfile: a table of single-cycle vectors for the
// write/read datapath, then hand-written sequences for clear, reset during a
// clear and out-of-range addressing (on a DEPTH=6 instance, where indices
// beyond the last entry are representable).
// -----------------------------------------------------------------------------
module tb_we_regfile;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int STRB  = 4;
    localparam int SDEPTH = 6;

    logic             clk = 1'b0;
    logic             rst;

    logic             wr_valid_in;
    logic             wr_ready_out;
    logic [AW-1:0]    wr_addr_in;
    logic [WIDTH-1:0] wr_data_in;
    logic [STRB-1:0]  wr_strb_in;
    logic             rd_en_in;
    logic [AW-1:0]    rd_addr_in;
    logic [WIDTH-1:0] rd_data_out;
    logic             rd_valid_out;
    logic             clr_in;
    logic             busy_out;
    logic [DEPTH-1:0] dirty_out;

    logic              s_wr_valid;
    logic              s_wr_ready;
    logic [AW-1:0]     s_wr_addr;
    logic [WIDTH-1:0]  s_wr_data;
    logic [STRB-1:0]   s_wr_strb;
    logic              s_rd_en;
    logic [AW-1:0]     s_rd_addr;
    logic [WIDTH-1:0]  s_rd_data;
    logic              s_rd_valid;
    logic              s_clr;
    logic              s_busy;
    logic [SDEPTH-1:0] s_dirty;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             wr_valid;
        logic [AW-1:0]    wr_addr;
        logic [WIDTH-1:0] wr_data;
        logic [STRB-1:0]  wr_strb;
        logic             rd_en;
        logic [AW-1:0]    rd_addr;
        logic [WIDTH-1:0] exp_rd_data;
        logic             exp_rd_valid;
        logic [DEPTH-1:0] exp_dirty;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    we_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid_in  (wr_valid_in),
        .wr_ready_out (wr_ready_out),
        .wr_addr_in   (wr_addr_in),
        .wr_data_in   (wr_data_in),
        .wr_strb_in   (wr_strb_in),
        .rd_en_in     (rd_en_in),
        .rd_addr_in   (rd_addr_in),
        .rd_data_out  (rd_data_out),
        .rd_valid_out (rd_valid_out),
        .clr_in       (clr_in),
        .busy_out     (busy_out),
        .dirty_out    (dirty_out)
    );

    we_regfile #(.WIDTH(WIDTH), .DEPTH(SDEPTH)) dut_small (
        .clk          (clk),
        .rst          (rst),
        .wr_valid_in  (s_wr_valid),
        .wr_ready_out (s_wr_ready),
        .wr_addr_in   (s_wr_addr),
        .wr_data_in   (s_wr_data),
        .wr_strb_in   (s_wr_strb),
        .rd_en_in     (s_rd_en),
        .rd_addr_in   (s_rd_addr),
        .rd_data_out  (s_rd_data),
        .rd_valid_out (s_rd_valid),
        .clr_in       (s_clr),
        .busy_out     (s_busy),
        .dirty_out    (s_dirty)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        wr_valid_in = v.wr_valid;
        wr_addr_in  = v.wr_addr;
        wr_data_in  = v.wr_data;
        wr_strb_in  = v.wr_strb;
        rd_en_in    = v.rd_en;
        rd_addr_in  = v.rd_addr;
        clr_in      = 1'b0;
    endtask

    task automatic idleInputs();
        wr_valid_in = 1'b0;
        wr_addr_in  = '0;
        wr_data_in  = '0;
        wr_strb_in  = '0;
        rd_en_in    = 1'b0;
        rd_addr_in  = '0;
        clr_in      = 1'b0;
    endtask

    task automatic readMain(input logic [AW-1:0] addr, input logic [31:0] exp, input string name);
        idleInputs();
        rd_en_in   = 1'b1;
        rd_addr_in = addr;
        step();
        checkOutput(name, rd_data_out, exp);
        checkOutput({name, "_valid"}, {31'b0, rd_valid_out}, 32'd1);
        idleInputs();
    endtask

    initial begin
        logic [31:0] v9_exp;
        int busy_cnt;

`ifdef WE_REGFILE_BYPASS_EN
        v9_exp = 32'h1234_5678;
`else
        v9_exp = 32'h0000_0000;
`endif
        //          wv  wa    wdata         ws     re  ra    exp_data      ev    dirty
        vecs[0]  = '{1'b0, 3'd0, 32'h0,          4'h0, 1'b1, 3'd3, 32'h0,          1'b1, 8'h00};
        vecs[1]  = '{1'b0, 3'd0, 32'h0,          4'h0, 1'b0, 3'd0, 32'h0,          1'b0, 8'h00};
        vecs[2]  = '{1'b1, 3'd2, 32'hDEAD_BEEF,  4'hF, 1'b0, 3'd0, 32'h0,          1'b0, 8'h04};
        vecs[3]  = '{1'b1, 3'd2, 32'h0000_00AA,  4'h1, 1'b0, 3'd0, 32'h0,          1'b0, 8'h04};
        vecs[4]  = '{1'b0, 3'd0, 32'h0,          4'h0, 1'b1, 3'd2, 32'hDEAD_BEAA,  1'b1, 8'h04};
        vecs[5]  = '{1'b1, 3'd0, 32'h1122_3344,  4'h6, 1'b0, 3'd0, 32'hDEAD_BEAA,  1'b0, 8'h05};
        vecs[6]  = '{1'b1, 3'd1, 32'hFFFF_FFFF,  4'h0, 1'b0, 3'd0, 32'hDEAD_BEAA,  1'b0, 8'h07};
        vecs[7]  = '{1'b0, 3'd0, 32'h0,          4'h0, 1'b1, 3'd0, 32'h0022_3300,  1'b1, 8'h07};
        vecs[8]  = '{1'b0, 3'd0, 32'h0,          4'h0, 1'b1, 3'd1, 32'h0,          1'b1, 8'h07};
        vecs[9]  = '{1'b1, 3'd5, 32'h1234_5678,  4'hF, 1'b1, 3'd5, v9_exp,         1'b1, 8'h27};
        vecs[10] = '{1'b0, 3'd0, 32'h0,          4'h0, 1'b1, 3'd5, 32'h1234_5678,  1'b1, 8'h27};
        vecs[11] = '{1'b0, 3'd0, 32'h0,          4'h0, 1'b0, 3'd0, 32'h1234_5678,  1'b0, 8'h27};
        vecs[12] = '{1'b1, 3'd7, 32'hCAFE_F00D,  4'hC, 1'b1, 3'd2, 32'hDEAD_BEAA,  1'b1, 8'hA7};
        vecs[13] = '{1'b0, 3'd0, 32'h0,          4'h0, 1'b1, 3'd7, 32'hCAFE_0000,  1'b1, 8'hA7};

        idleInputs();
        s_wr_valid = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_wr_strb = '0;
        s_rd_en = 1'b0; s_rd_addr = '0; s_clr = 1'b0;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_rd_data",  rd_data_out, 32'h0);
        checkOutput("rst_rd_valid", {31'b0, rd_valid_out}, 32'd0);
        checkOutput("rst_busy",     {31'b0, busy_out}, 32'd0);
        checkOutput("rst_ready",    {31'b0, wr_ready_out}, 32'd1);
        checkOutput("rst_dirty",    {24'b0, dirty_out}, 32'h0);

        $display("[TB] vector table");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("vec%0d_rd_data", i), rd_data_out, vecs[i].exp_rd_data);
            checkOutput($sformatf("vec%0d_rd_valid", i), {31'b0, rd_valid_out}, {31'b0, vecs[i].exp_rd_valid});
            checkOutput($sformatf("vec%0d_dirty", i), {24'b0, dirty_out}, {24'b0, vecs[i].exp_dirty});
        end
        idleInputs();

        $display("[TB] clear sequence with coincident write");
        wr_valid_in = 1'b1;
        wr_addr_in  = 3'd3;
        wr_data_in  = 32'h0000_BEEF;
        wr_strb_in  = 4'h3;
        clr_in      = 1'b1;
        step();
        checkOutput("clr_start_busy",  {31'b0, busy_out}, 32'd1);
        checkOutput("clr_start_ready", {31'b0, wr_ready_out}, 32'd0);
        checkOutput("clr_start_dirty", {24'b0, dirty_out}, 32'hAF);
        busy_cnt = 1;
        for (int i = 1; i <= 20; i++) begin
            idleInputs();
            clr_in = (i <= 2);
            if (i == 3) begin
                rd_en_in = 1'b1; rd_addr_in = 3'd0;
            end
            if (i == 4) begin
                rd_en_in = 1'b1; rd_addr_in = 3'd7;
            end
            if (i == 5) begin
                wr_valid_in = 1'b1; wr_addr_in = 3'd2;
                wr_data_in = 32'h0000_0777; wr_strb_in = 4'hF;
            end
            step();
            if (i == 3) checkOutput("clr_read_cleared", rd_data_out, 32'h0);
            if (i == 4) checkOutput("clr_read_pending", rd_data_out, 32'hCAFE_0000);
            if (busy_out) begin
                busy_cnt++;
                checkOutput($sformatf("clr_ready_low_%0d", i), {31'b0, wr_ready_out}, 32'd0);
            end else begin
                break;
            end
        end
        idleInputs();
        checkOutput("clr_busy_cycles", busy_cnt, 32'd8);
        checkOutput("clr_end_ready",   {31'b0, wr_ready_out}, 32'd1);
        checkOutput("clr_end_dirty",   {24'b0, dirty_out}, 32'h0);
        for (int j = 0; j < DEPTH; j++) begin
            readMain(AW'(j), 32'h0, $sformatf("clr_entry%0d", j));
        end

        $display("[TB] reset during clear");
        wr_valid_in = 1'b1; wr_addr_in = 3'd7; wr_data_in = 32'h55; wr_strb_in = 4'hF;
        step();
        idleInputs();
        clr_in = 1'b1;
        step();
        idleInputs();
        step();
        rd_en_in = 1'b1; rd_addr_in = 3'd7;
        step();
        checkOutput("rstclr_pre_read", rd_data_out, 32'h55);
        checkOutput("rstclr_pre_busy", {31'b0, busy_out}, 32'd1);
        rst = 1'b1;
        wr_valid_in = 1'b1; wr_addr_in = 3'd1; wr_data_in = 32'hFF; wr_strb_in = 4'hF;
        rd_en_in = 1'b1; rd_addr_in = 3'd7; clr_in = 1'b1;
        step();
        rst = 1'b0;
        idleInputs();
        checkOutput("rstclr_busy",     {31'b0, busy_out}, 32'd0);
        checkOutput("rstclr_ready",    {31'b0, wr_ready_out}, 32'd1);
        checkOutput("rstclr_dirty",    {24'b0, dirty_out}, 32'h0);
        checkOutput("rstclr_rd_valid", {31'b0, rd_valid_out}, 32'd0);
        checkOutput("rstclr_rd_data",  rd_data_out, 32'h0);
        step();
        checkOutput("rstclr_idle_busy", {31'b0, busy_out}, 32'd0);
        readMain(3'd7, 32'h0, "rstclr_entry7");
        readMain(3'd1, 32'h0, "rstclr_entry1");

        $display("[TB] out-of-range addressing on DEPTH=6 instance");
        checkOutput("oor_ready", {31'b0, s_wr_ready}, 32'd1);
        s_wr_valid = 1'b1; s_wr_addr = 3'd6; s_wr_data = 32'hFFFF_FFFF; s_wr_strb = 4'hF;
        step();
        checkOutput("oor_dirty_after_wr", {26'b0, s_dirty}, 32'h0);
        s_wr_addr = 3'd5; s_wr_data = 32'hA5A5_A5A5;
        step();
        s_wr_valid = 1'b0;
        checkOutput("oor_dirty_valid_wr", {26'b0, s_dirty}, 32'h20);
        s_rd_en = 1'b1; s_rd_addr = 3'd5;
        step();
        checkOutput("oor_read5", s_rd_data, 32'hA5A5_A5A5);
        s_rd_addr = 3'd6;
        step();
        checkOutput("oor_read6",       s_rd_data, 32'h0);
        checkOutput("oor_read6_valid", {31'b0, s_rd_valid}, 32'd1);
        s_rd_addr = 3'd7;
        s_wr_valid = 1'b1; s_wr_addr = 3'd7; s_wr_data = 32'h1234_5678; s_wr_strb = 4'hF;
        step();
        s_wr_valid = 1'b0; s_rd_en = 1'b0;
        checkOutput("oor_read7_bypass", s_rd_data, 32'h0);
        checkOutput("oor_dirty_final",  {26'b0, s_dirty}, 32'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
